inject_queue: RTL
=================

INJECT_QUEUE -- requirements
Module: inject_queue

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter LOCAL_ROW, default 3'b100, giving this node's row.
REQ-003 The block SHALL have parameter LOCAL_COL, default 3'b100, giving this node's column.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port pe_flit, input, 10 bits: flit from the processing element; [9] reserved, [8:6] direction (ignored), [5:3] destination row, [2:0] destination column.
REQ-007 The block SHALL have port pe_valid, input, 1 bit: pe_flit is offered this cycle.
REQ-008 The block SHALL have port pe_ready, output, 1 bit: the queue accepts an offered flit this cycle.
REQ-009 The block SHALL have port localad, output, 10 bits: head flit presented to the router injection stage.
REQ-010 The block SHALL have port local_valid, output, 1 bit: localad holds a real flit.
REQ-011 The block SHALL have port inj_taken, input, 1 bit: the router consumed localad this cycle because a free channel existed.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 The block SHALL have port stall_cnt, output, 8 bits: consecutive cycles the head has waited.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a flit was offered while the queue was full.
REQ-015 The block SHALL have port self_drop, output, 1 bit: one-cycle pulse when a self-addressed flit is discarded.

Function
REQ-016 The queue SHALL be a circular buffer of DEPTH 10-bit entries with write pointer, read pointer and occupancy counter; pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 pe_ready SHALL equal (count != DEPTH), computed from registered state only, with no combinational path from inj_taken.
REQ-018 Push SHALL occur when pe_valid && pe_ready && the destination is not (LOCAL_ROW, LOCAL_COL).
  - Stored entry: {1'b1, 3'b000, pe_flit[5:0]}.
  - Bits [8:6] are cleared because the injection stage assigns direction.
REQ-019 When pe_valid && pe_ready and the destination equals (LOCAL_ROW, LOCAL_COL), the flit SHALL be discarded, no push SHALL occur, and self_drop SHALL pulse high for the following cycle.
REQ-020 local_valid SHALL equal (count != 0); localad SHALL show the entry at the read pointer when local_valid is 1, and SHALL be 10'b0 otherwise.
  - Show-ahead: a flit pushed at edge N is visible at localad after edge N.
REQ-021 Pop SHALL occur when inj_taken && local_valid; inj_taken while local_valid is 0 SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
  - When full, push is blocked by pe_ready even if a pop occurs in the same cycle.
REQ-023 When empty, a push and an inj_taken in the same cycle SHALL result in push only: count becomes 1.
REQ-024 overflow SHALL set when pe_valid && !pe_ready, and SHALL clear only on reset.
REQ-025 stall_cnt update rules:
  - increments each cycle local_valid && !inj_taken;
  - saturates at 255;
  - clears to 0 on a pop or whenever the queue is empty.
REQ-026 Latency: PE to localad SHALL be 1 cycle when empty; throughput SHALL be 1 flit per cycle.

Reset
REQ-027 While reset is high, asynchronously:
  - pointers = 0, count = 0, local_valid = 0, localad = 10'b0;
  - pe_ready = 1, stall_cnt = 0, overflow = 0, self_drop = 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued flits; buffer contents need not be cleared.
REQ-029 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-030 Scenario: after reset, push pe_flit=10'h01A (row 3, col 2) -> next cycle local_valid=1, localad=10'h21A, count=1.
REQ-031 Scenario: push 4 flits with inj_taken=0 -> count=4, pe_ready=0; a 5th offer sets overflow=1 and count stays 4.
REQ-032 Scenario: with the queue full, assert inj_taken and pe_valid together -> count=3, the 5th flit is not stored, localad shows the 2nd flit.
REQ-033 Scenario: offer pe_flit=10'h024 (row 4, col 4) -> self_drop=1 for one cycle, count unchanged.
REQ-034 Scenario: hold one flit with inj_taken=0 for 300 cycles -> stall_cnt=255; then pulse inj_taken -> stall_cnt=0, local_valid=0.
REQ-035 Scenario: assert reset asynchronously with count=3 -> count=0, local_valid=0 immediately; overflow cleared.

Source files
------------

// File: rtl/inject_queue.sv
// Injection queue between a processing element and the router injection stage.
// Show-ahead, one cycle from PE to localad; pe_ready drops only when full, from registered state.
module inject_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [2:0] LOCAL_ROW = 3'b100,
    parameter logic [2:0] LOCAL_COL = 3'b100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               pe_flit,
    input  logic                     pe_valid,
    output logic                     pe_ready,
    output logic [9:0]               localad,
    output logic                     local_valid,
    input  logic                     inj_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               stall_cnt,
    output logic                     overflow,
    output logic                     self_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    stall_q, stall_d;
    logic          overflow_q, overflow_d;
    logic          self_drop_q, self_drop_d;

    logic          dest_self;
    logic          accept;
    logic          push;
    logic          pop;

    assign pe_ready    = (count_q != CW'(DEPTH));
    assign local_valid = (count_q != '0);
    assign localad     = local_valid ? mem_q[rd_ptr_q] : 10'b0;
    assign count       = count_q;
    assign stall_cnt   = stall_q;
    assign overflow    = overflow_q;
    assign self_drop   = self_drop_q;

    always_comb begin
        dest_self   = (pe_flit[5:3] == LOCAL_ROW) && (pe_flit[2:0] == LOCAL_COL);
        accept      = pe_valid && pe_ready;
        push        = accept && !dest_self;
        pop         = inj_taken && local_valid;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q || (pe_valid && !pe_ready);
        self_drop_d = accept && dest_self;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head wait time restarts whenever the head leaves or there is no head.
        if (!local_valid || pop) begin
            stall_d = 8'd0;
        end else if (stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_q     <= 8'd0;
            overflow_q  <= 1'b0;
            self_drop_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
            self_drop_q <= self_drop_d;
        end
    end

    // Direction bits are cleared; the injection stage assigns the output port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {1'b1, 3'b000, pe_flit[5:0]};
        end
    end

endmodule
